mux8_rr_arbiter: RTL and testbench
==================================

Name: mux8_rr_arbiter

Overview:
Round-robin arbiter and sequencer for the 8-input, 4-bit select datapath. It shares one 4-bit output channel among eight requesters. It drives the 3-bit select (S) of the 8:1 mux, returns per-requester acknowledges, and registers the selected nibble into a valid/ready output stage. Bursts are bounded so that no requester starves the others.

Parameters:
BURST_MAX, 4, max beats per grant before forced re-arbitration; legal range 1..8.

Ports:
Clock  input  1  system clock; all state updates on rising edge.
Reset  input  1  synchronous, active-high reset.
W0..W7  input  4 each  requester data nibbles.
req  input  8  request vector; req[i] pairs with Wi; must be held until acked.
ack  output  8  combinational; ack[i]=1 means Wi is captured at this edge.
gnt  output  8  registered one-hot of current grant; all-zero when no grant.
S  output  3  registered select index of current/last grant.
F  output  4  registered output data.
out_valid  output  1  F holds a valid beat.
out_ready  input  1  downstream accepts F when out_valid && out_ready.
busy  output  1  1 while state == GRANT.

Behaviour:
- States: IDLE, GRANT.
- Reset values: state=IDLE, S=0, last=7 (so req[0] has top priority first), beat_cnt=0, gnt=0, ack=0, F=0, out_valid=0, busy=0.
- Reset asserted mid-burst aborts the burst the same edge. An in-flight out_valid beat is dropped.
- Output slot is free when !out_valid || out_ready.
- IDLE:
  - If req==0, stay.
  - Otherwise pick the first set bit scanning (last+1) mod 8 upward, wrapping 7->0. Load S=that index, gnt=1<<S, beat_cnt=0, go to GRANT.
  - ack=0 in IDLE, so there is a one-cycle arbitration bubble.
- GRANT:
  - ack[S] = req[S] && slot_free; all other ack bits are 0.
  - On ack: F<=W[S], out_valid<=1, beat_cnt<=beat_cnt+1.
  - No ack but out_valid && out_ready: out_valid<=0.
  - Exit to IDLE (gnt<=0, last<=S, beat_cnt<=0) when either:
    (a) req[S]==0, or
    (b) ack occurs with beat_cnt==BURST_MAX-1; the beat is still transferred.
  - S keeps its value in IDLE until the next grant.
- Backpressure: while out_valid && !out_ready, F and out_valid hold, no ack is issued, and beat_cnt holds. The grant is kept (no timeout).
- Latency: a req seen in IDLE at edge n produces gnt at edge n+1. The first ack can fire in cycle n+1, and F/out_valid appear at edge n+2.
- Throughput: 1 beat/cycle inside a burst with out_ready=1. There is one bubble cycle between grants.
- beat_cnt is 4 bits and never exceeds BURST_MAX-1.
- Requester withdrawing req before ack is a protocol violation; the block simply treats it as exit condition (a).

Optional Feature:
MUX8_ARB_LOCK_EN.
- Defined: adds input port lock (1 bit). While lock=1 in GRANT, exit condition (b) is suppressed, so the burst continues past BURST_MAX. beat_cnt saturates at BURST_MAX-1. Exit is then by req[S]==0 only. lock has no effect in IDLE.
- Undefined: no lock port, and bursts always end at BURST_MAX.

Test Plan:
1. Reset: assert Reset 2 cycles with req=8'hFF -> ack=0, gnt=0, S=0, F=0, out_valid=0, busy=0. After release, first grant is gnt=8'h01.
2. Single requester: req=8'h08, W3=4'hA, out_ready=1, held 10 cycles -> gnt=8'h08, S=3. Four beats of F=4'hA, then busy=0 for 1 cycle, then S=3 regranted.
3. Fairness: req=8'hFF constant, out_ready=1, BURST_MAX=1 -> S sequence 0,1,2,3,4,5,6,7,0, each separated by one bubble cycle.
4. Backpressure: mid-burst set out_ready=0 for 3 cycles -> out_valid=1, F frozen, ack=0, beat_cnt frozen. After release, the remaining beats complete with total beats = BURST_MAX.
5. Early release: req[5] dropped after 2 acked beats -> IDLE next edge, last=5. Pending req[2]|req[6] then grants 6 before 2.
6. Reset mid-burst (and, with MUX8_ARB_LOCK_EN, lock=1 for 6 beats) -> state returns to reset values on that edge. With lock=1, 6 consecutive beats are observed before exit.

Source files
------------

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one 4-bit channel among eight requesters, with bounded bursts.
// Optional MUX8_ARB_LOCK_EN adds a 'lock' input that lets the granted requester burst past BURST_MAX.
//
// state | meaning
// IDLE  | no grant; arbitrate among pending requests (one-cycle bubble)
// GRANT | S owns the channel; beats move whenever the output slot is free
module mux8_rr_arbiter #(
  parameter int BURST_MAX = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] W0,
  input  logic [3:0] W1,
  input  logic [3:0] W2,
  input  logic [3:0] W3,
  input  logic [3:0] W4,
  input  logic [3:0] W5,
  input  logic [3:0] W6,
  input  logic [3:0] W7,
  input  logic [7:0] req,
  input  logic       out_ready,
`ifdef MUX8_ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [7:0] ack,
  output logic [7:0] gnt,
  output logic [2:0] S,
  output logic [3:0] F,
  output logic       out_valid,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] CNT_MAX = 4'(BURST_MAX - 1);

  state_t     state, state_nxt;
  logic [2:0] last;
  logic [3:0] beat_cnt;
  logic [3:0] w_sel;
  logic [2:0] pick;
  logic [2:0] cand;
  logic       slot_free;
  logic       ack_any;
  logic       cnt_at_max;
  logic       lock_on;
  logic       burst_end;
  logic       grant_exit;

`ifdef MUX8_ARB_LOCK_EN
  assign lock_on = lock;
`else
  assign lock_on = 1'b0;
`endif

  always_comb begin
    case (S)
      3'd0:    w_sel = W0;
      3'd1:    w_sel = W1;
      3'd2:    w_sel = W2;
      3'd3:    w_sel = W3;
      3'd4:    w_sel = W4;
      3'd5:    w_sel = W5;
      3'd6:    w_sel = W6;
      default: w_sel = W7;
    endcase
  end

  // Scan from farthest to nearest so the first set bit after 'last' wins.
  always_comb begin
    pick = last;
    cand = last;
    for (int k = 8; k >= 1; k--) begin
      cand = last + 3'(k);
      if (req[cand]) pick = cand;
    end
  end

  assign slot_free  = !out_valid || out_ready;
  assign ack_any    = (state == GRANT) && req[S] && slot_free;
  assign cnt_at_max = (beat_cnt == CNT_MAX);
  assign burst_end  = ack_any && cnt_at_max && !lock_on;
  assign grant_exit = !req[S] || burst_end;

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = GRANT;
      GRANT:   if (grant_exit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack = '0;
    if (ack_any) ack[S] = 1'b1;
    busy = (state == GRANT);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      S         <= 3'd0;
      last      <= 3'd7;
      beat_cnt  <= 4'd0;
      gnt       <= 8'd0;
      F         <= 4'd0;
      out_valid <= 1'b0;
    end else begin
      if (ack_any) begin
        F         <= w_sel;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (|req) begin
            S        <= pick;
            gnt      <= 8'd1 << pick;
            beat_cnt <= 4'd0;
          end
        end
        GRANT: begin
          if (grant_exit) begin
            gnt      <= 8'd0;
            last     <= S;
            beat_cnt <= 4'd0;
          end else if (ack_any && !cnt_at_max) begin
            beat_cnt <= beat_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: expected beats are queued per phase and popped by a monitor.
// Two instances: BURST_MAX=4 (main) and BURST_MAX=1 (fairness rotation).
module tb_mux8_rr_arbiter;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [3:0] wv [8];
  logic [7:0] req, req1;
  logic       out_ready, out_ready1;
  logic       lock;
  logic [7:0] ack, gnt, ack1, gnt1;
  logic [2:0] S, S1;
  logic [3:0] F, F1;
  logic       out_valid, busy, out_valid1, busy1;

  logic [3:0] q0 [$];
  logic [3:0] q1 [$];
  int         errors = 0;
  int         checks = 0;

  always #5 Clock = ~Clock;

  mux8_rr_arbiter #(.BURST_MAX(4)) u_dut (
    .Clock(Clock), .Reset(Reset),
    .W0(wv[0]), .W1(wv[1]), .W2(wv[2]), .W3(wv[3]),
    .W4(wv[4]), .W5(wv[5]), .W6(wv[6]), .W7(wv[7]),
    .req(req), .out_ready(out_ready),
`ifdef MUX8_ARB_LOCK_EN
    .lock(lock),
`endif
    .ack(ack), .gnt(gnt), .S(S), .F(F), .out_valid(out_valid), .busy(busy)
  );

  mux8_rr_arbiter #(.BURST_MAX(1)) u_dut1 (
    .Clock(Clock), .Reset(Reset),
    .W0(wv[0]), .W1(wv[1]), .W2(wv[2]), .W3(wv[3]),
    .W4(wv[4]), .W5(wv[5]), .W6(wv[6]), .W7(wv[7]),
    .req(req1), .out_ready(out_ready1),
`ifdef MUX8_ARB_LOCK_EN
    .lock(1'b0),
`endif
    .ack(ack1), .gnt(gnt1), .S(S1), .F(F1), .out_valid(out_valid1), .busy(busy1)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // A transfer happens at the next rising edge when valid && ready are seen here.
  always @(negedge Clock) begin
    if (Reset === 1'b0 && out_valid && out_ready) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL beat0_unexpected: got F=%0h expected no beat at %0t", F, $time);
      end else begin
        chk("beat0_data", 8'(F), 8'(q0.pop_front()));
      end
    end
    if (Reset === 1'b0 && out_valid1 && out_ready1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL beat1_unexpected: got F=%0h expected no beat at %0t", F1, $time);
      end else begin
        chk("beat1_data", 8'(F1), 8'(q1.pop_front()));
      end
    end
  end

  initial begin
    logic [2:0] e3;
    wv[0] = 4'h1; wv[1] = 4'h2; wv[2] = 4'h3; wv[3] = 4'hA;
    wv[4] = 4'h5; wv[5] = 4'h6; wv[6] = 4'h7; wv[7] = 4'h8;
    Reset = 1'b1; req = 8'hFF; req1 = 8'h00;
    out_ready = 1'b1; out_ready1 = 1'b1; lock = 1'b0;

    // Reset held two cycles with every request pending
    step(); step();
    chk("rst_ack", ack, 8'h00);
    chk("rst_gnt", gnt, 8'h00);
    chk("rst_S", 8'(S), 8'h0);
    chk("rst_F", 8'(F), 8'h0);
    chk("rst_valid", 8'(out_valid), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_gnt1", gnt1, 8'h00);
    Reset = 1'b0;
    step();
    chk("first_gnt", gnt, 8'h01);
    chk("first_busy", 8'(busy), 8'h1);
    chk("first_ack", ack, 8'h01);
    req = 8'h00;
    step();
    chk("drop_idle", 8'(busy), 8'h0);

    // Single requester: two 4-beat bursts separated by one bubble
    req = 8'h08;
    repeat (8) q0.push_back(wv[3]);
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 1) begin
        chk("single_gnt", gnt, 8'h08);
        chk("single_S", 8'(S), 8'h3);
        chk("single_busy", 8'(busy), 8'h1);
      end
      if (i == 5) begin
        chk("single_bubble", 8'(busy), 8'h0);
        chk("single_bubble_gnt", gnt, 8'h00);
        chk("single_S_hold", 8'(S), 8'h3);
      end
      if (i == 6) chk("single_regrant", gnt, 8'h08);
      if (i == 10) chk("single_end", 8'(busy), 8'h0);
    end
    req = 8'h00;

    // Fairness on the BURST_MAX=1 instance
    req1 = 8'hFF;
    for (int k = 0; k < 9; k++) q1.push_back(wv[k % 8]);
    for (int i = 1; i <= 18; i++) begin
      step();
      if (i % 2 == 1) begin
        e3 = 3'(((i - 1) / 2) % 8);
        chk("rr_S", 8'(S1), 8'(e3));
        chk("rr_gnt", gnt1, 8'd1 << e3);
      end else begin
        chk("rr_bubble", 8'(busy1), 8'h0);
      end
    end
    req1 = 8'h00;

    // Backpressure mid-burst
    req = 8'h10;
    repeat (4) q0.push_back(wv[4]);
    step();
    chk("bp_gnt", gnt, 8'h10);
    step(); step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", 8'(out_valid), 8'h1);
      chk("bp_F", 8'(F), 8'(wv[4]));
      chk("bp_ack", ack, 8'h00);
      chk("bp_busy", 8'(busy), 8'h1);
    end
    out_ready = 1'b1;
    step();
    chk("bp_still_busy", 8'(busy), 8'h1);
    step();
    chk("bp_exit", 8'(busy), 8'h0);
    req = 8'h00;

    // Early release of req[5], then 6 before 2
    req = 8'h20;
    repeat (2) q0.push_back(wv[5]);
    repeat (4) q0.push_back(wv[6]);
    repeat (4) q0.push_back(wv[2]);
    step();
    chk("er_S", 8'(S), 8'h5);
    step(); step();
    req = 8'h44;
    step();
    chk("er_idle", 8'(busy), 8'h0);
    chk("er_gnt0", gnt, 8'h00);
    step();
    chk("er_S6", 8'(S), 8'h6);
    chk("er_gnt6", gnt, 8'h40);
    repeat (4) step();
    chk("er_bubble", 8'(busy), 8'h0);
    step();
    chk("er_S2", 8'(S), 8'h2);
    chk("er_gnt2", gnt, 8'h04);
    repeat (4) step();
    req = 8'h00;

    // Reset mid-burst drops the in-flight beat
    req = 8'h02;
    q0.push_back(wv[1]);
    step();
    chk("mr_S", 8'(S), 8'h1);
    step(); step();
    Reset = 1'b1; req = 8'h00;
    step();
    chk("mr_gnt", gnt, 8'h00);
    chk("mr_S0", 8'(S), 8'h0);
    chk("mr_F", 8'(F), 8'h0);
    chk("mr_valid", 8'(out_valid), 8'h0);
    chk("mr_busy", 8'(busy), 8'h0);
    chk("mr_ack", ack, 8'h00);
    Reset = 1'b0; req = 8'h81;
    step();
    chk("mr_prio", gnt, 8'h01);
    req = 8'h00;
    step(); step();

`ifdef MUX8_ARB_LOCK_EN
    req = 8'h01; lock = 1'b1;
    repeat (6) q0.push_back(wv[0]);
    step();
    chk("lk_gnt", gnt, 8'h01);
    for (int i = 2; i <= 7; i++) begin
      step();
      if (i == 5) chk("lk_past_max", 8'(busy), 8'h1);
    end
    req = 8'h00; lock = 1'b0;
    step();
    chk("lk_exit", 8'(busy), 8'h0);
`endif

    repeat (3) step();
    chk("q0_drained", 8'(q0.size()), 8'h0);
    chk("q1_drained", 8'(q1.size()), 8'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
